// File: rtl/flash_prog_ctrl_pkg.sv
// rtl/flash_prog_ctrl_pkg.sv - shared widths, types and state encoding for flash_prog_ctrl
//
// Purpose: flash word address/data widths and the sequencer state constants.
// Ports:   none (package).
package flash_prog_ctrl_pkg;

  localparam int ADDR_W = 22;  // flash word address bus
  localparam int DATA_W = 16;  // flash data bus

  typedef logic [ADDR_W-1:0] flash_addr_t;
  typedef logic [DATA_W-1:0] flash_data_t;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_WAIT_LO    = 4'd1;
  localparam logic [3:0] S_WAIT_HI    = 4'd2;
  localparam logic [3:0] S_ERASE_REQ  = 4'd3;
  localparam logic [3:0] S_ERASE_WAIT = 4'd4;
  localparam logic [3:0] S_WRITE_REQ  = 4'd5;
  localparam logic [3:0] S_WRITE_WAIT = 4'd6;
  localparam logic [3:0] S_READ_REQ   = 4'd7;
  localparam logic [3:0] S_READ_WAIT  = 4'd8;
  localparam logic [3:0] S_NEXT       = 4'd9;
  localparam logic [3:0] S_FIN        = 4'd10;
  localparam logic [3:0] S_ERR        = 4'd11;

endpackage

// File: rtl/flash_prog_ctrl_if.sv
// rtl/flash_prog_ctrl_if.sv - bus between the programming sequencer and the word-wide flash driver
//
// Purpose: groups the driver address/data, level enables and finish levels.
// Modports: master = sequencer (drives address, write data, enables)
//           slave  = flash driver (drives read data, finish levels)
interface flash_prog_ctrl_if;
  import flash_prog_ctrl_pkg::*;

  flash_addr_t drv_addr;
  flash_data_t drv_wdata;
  flash_data_t drv_rdata;
  logic        drv_en_read;
  logic        drv_en_erase;
  logic        drv_en_write;
  logic        drv_read_finish;
  logic        drv_erase_finish;
  logic        drv_write_finish;

  modport master (
    output drv_addr, drv_wdata, drv_en_read, drv_en_erase, drv_en_write,
    input  drv_rdata, drv_read_finish, drv_erase_finish, drv_write_finish
  );

  modport slave (
    input  drv_addr, drv_wdata, drv_en_read, drv_en_erase, drv_en_write,
    output drv_rdata, drv_read_finish, drv_erase_finish, drv_write_finish
  );

endinterface

// File: rtl/flash_prog_ctrl_req_hs.sv
// rtl/flash_prog_ctrl_req_hs.sv - enable/finish handshake for one flash driver operation
//
// Purpose: drives one driver enable while the sequencer requests it and
//          reports when the request phase may end and when the op completes.
// Ports:   clk, rst        clock, synchronous active-high reset
//          req             sequencer is in the request state for this op
//          in_wait         sequencer is in the wait state for this op
//          finish          driver finish level for this op
//          en              driver enable
//          ack             last cycle of the request phase
//          cmpl            driver finished while waiting
// HOLD=0: ack when finish falls (driver started). HOLD=N: ack on Nth cycle.
module flash_prog_ctrl_req_hs #(
  parameter int HOLD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic in_wait,
  input  logic finish,
  output logic en,
  output logic ack,
  output logic cmpl
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_done;

  // Cycles of enable so far; the Nth cycle is the one at count N-1.
  assign hold_done = (cnt_q == CW'(HOLD - 1));

  assign en   = req;
  assign ack  = req & ((HOLD == 0) ? ~finish : hold_done);
  assign cmpl = in_wait & finish;

  always_comb begin
    cnt_d = '0;
    if (req && !ack) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/flash_prog_ctrl.sv
// rtl/flash_prog_ctrl.sv - byte stream to flash word programmer with erase and read-back verify
//
// Purpose: packs UART bytes into little-endian 16-bit words and programs them
//          to consecutive flash word addresses, erasing each block on entry.
// Ports:   clk, rst                  clock, synchronous active-high reset
//          start/base_addr/word_count run request (accepted only when idle)
//          rx_data/rx_valid/rx_ready byte input
//          drv                       flash driver bus (master side)
//          busy/done/error/err_addr/words_done  run status
module flash_prog_ctrl
  import flash_prog_ctrl_pkg::*;
#(
  parameter int BLOCK_BITS = 16,
  parameter int READ_HOLD  = 8,
  parameter bit VERIFY     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  flash_addr_t       base_addr,
  input  flash_addr_t       word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  flash_prog_ctrl_if.master drv,
  output logic              busy,
  output logic              done,
  output logic              error,
  output flash_addr_t       err_addr,
  output flash_addr_t       words_done
);

  logic [3:0]  state_q, state_d;
  flash_addr_t cur_addr_q, cur_addr_d;
  flash_addr_t remaining_q, remaining_d;
  flash_addr_t words_done_q, words_done_d;
  flash_addr_t err_addr_q, err_addr_d;
  flash_data_t word_q, word_d;
  flash_data_t rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic erase_ack, erase_cmpl, write_ack, write_cmpl, read_ack, read_cmpl;
  logic overrun;

  flash_prog_ctrl_req_hs #(.HOLD(0)) u_erase_hs (
    .clk(clk), .rst(rst),
    .req(state_q == S_ERASE_REQ), .in_wait(state_q == S_ERASE_WAIT),
    .finish(drv.drv_erase_finish),
    .en(drv.drv_en_erase), .ack(erase_ack), .cmpl(erase_cmpl)
  );

  flash_prog_ctrl_req_hs #(.HOLD(0)) u_write_hs (
    .clk(clk), .rst(rst),
    .req(state_q == S_WRITE_REQ), .in_wait(state_q == S_WRITE_WAIT),
    .finish(drv.drv_write_finish),
    .en(drv.drv_en_write), .ack(write_ack), .cmpl(write_cmpl)
  );

  flash_prog_ctrl_req_hs #(.HOLD(READ_HOLD)) u_read_hs (
    .clk(clk), .rst(rst),
    .req(state_q == S_READ_REQ), .in_wait(state_q == S_READ_WAIT),
    .finish(drv.drv_read_finish),
    .en(drv.drv_en_read), .ack(read_ack), .cmpl(read_cmpl)
  );

  assign rx_ready = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
  // A byte arriving while a run cannot take it is lost data; ERR already aborts.
  assign overrun  = rx_valid && !rx_ready && busy_q && (state_q != S_ERR);

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    words_done_d = words_done_q;
    err_addr_d   = err_addr_q;
    word_d       = word_q;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    if (overrun) begin
      err_addr_d = cur_addr_q;
      state_d    = S_ERR;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          cur_addr_d   = base_addr;
          remaining_d  = word_count;
          words_done_d = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          state_d      = (word_count == '0) ? S_FIN : S_WAIT_LO;
        end
        S_WAIT_LO: if (rx_valid) begin
          word_d[7:0] = rx_data;
          state_d     = S_WAIT_HI;
        end
        S_WAIT_HI: if (rx_valid) begin
          word_d[15:8] = rx_data;
          // Only a block-aligned word erases, so an unaligned first word never does.
          state_d = (cur_addr_q[BLOCK_BITS-1:0] == '0) ? S_ERASE_REQ : S_WRITE_REQ;
        end
        S_ERASE_REQ:  if (erase_ack)  state_d = S_ERASE_WAIT;
        S_ERASE_WAIT: if (erase_cmpl) state_d = S_WRITE_REQ;
        S_WRITE_REQ:  if (write_ack)  state_d = S_WRITE_WAIT;
        S_WRITE_WAIT: if (write_cmpl) state_d = VERIFY ? S_READ_REQ : S_NEXT;
        S_READ_REQ: if (read_ack) begin
          rdata_d = drv.drv_rdata;
          state_d = S_READ_WAIT;
        end
        S_READ_WAIT: if (read_cmpl) begin
          if (rdata_q != word_q) begin
            err_addr_d = cur_addr_q;
            state_d    = S_ERR;
          end else begin
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          cur_addr_d   = cur_addr_q + 1'b1;
          words_done_d = words_done_q + 1'b1;
          remaining_d  = remaining_q - 1'b1;
          state_d      = (remaining_q == 22'd1) ? S_FIN : S_WAIT_LO;
        end
        S_FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        S_ERR: begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
      err_addr_q   <= '0;
      word_q       <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      words_done_q <= words_done_d;
      err_addr_q   <= err_addr_d;
      word_q       <= word_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign drv.drv_addr  = cur_addr_q;
  assign drv.drv_wdata = word_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_addr      = err_addr_q;
  assign words_done    = words_done_q;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// tb/tb_flash_prog_ctrl.sv - self-checking bench for flash_prog_ctrl
module tb_flash_prog_ctrl;

  localparam int READ_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [21:0] base_addr, word_count;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        busy, done, error;
  logic [21:0] err_addr, words_done;

  always #5 clk = ~clk;

  flash_prog_ctrl_if dif ();

  flash_prog_ctrl #(.BLOCK_BITS(16), .READ_HOLD(READ_HOLD), .VERIFY(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .drv(dif),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr), .words_done(words_done)
  );

  typedef struct {
    int          kind;   // 0 erase, 1 write, 2 read
    logic [21:0] addr;
    logic [15:0] data;
  } op_t;

  op_t         op_log[$];
  op_t         exp_q[$];
  logic [7:0]  byte_q[$];
  logic [15:0] mem [logic [21:0]];
  bit          corrupt_en = 1'b0;
  logic [21:0] corrupt_a  = '0;
  int          vectors    = 0;
  int          miscompares = 0;

  task automatic set_finish(input int kind, input logic v);
    if (kind == 0)      dif.drv_erase_finish = v;
    else if (kind == 1) dif.drv_write_finish = v;
    else                dif.drv_read_finish  = v;
  endtask

  function automatic logic enable_of(input int kind);
    if (kind == 0) return dif.drv_en_erase;
    if (kind == 1) return dif.drv_en_write;
    return dif.drv_en_read;
  endfunction

  // Behavioural flash driver: acks by dropping finish, finishes after the enable drops.
  initial begin : drv_model
    op_t op;
    int  k;
    dif.drv_read_finish  = 1'b1;
    dif.drv_erase_finish = 1'b1;
    dif.drv_write_finish = 1'b1;
    dif.drv_rdata        = '0;
    forever begin
      @(posedge clk); #1;
      if (dif.drv_en_erase || dif.drv_en_write || dif.drv_en_read) begin
        op.addr = dif.drv_addr;
        op.data = dif.drv_wdata;
        if (dif.drv_en_erase)      op.kind = 0;
        else if (dif.drv_en_write) op.kind = 1;
        else                       op.kind = 2;
        if (op.kind != 1) op.data = '0;
        op_log.push_back(op);
        if (op.kind == 1) mem[op.addr] = op.data;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        set_finish(op.kind, 1'b0);
        if (op.kind == 2) begin
          repeat (2) begin @(posedge clk); #1; end
          if (corrupt_en && op.addr == corrupt_a) dif.drv_rdata = 16'hFFFF;
          else if (mem.exists(op.addr))           dif.drv_rdata = mem[op.addr];
          else                                    dif.drv_rdata = 16'hFFFF;
        end
        k = 0;
        while (enable_of(op.kind) && k < 64) begin @(posedge clk); #1; k++; end
        if (k >= 64) begin
          vectors++; miscompares++;
          $display("FAIL enable_drop kind=%0d addr=%h still high after %0d cycles, required low", op.kind, op.addr, k);
        end
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        set_finish(op.kind, 1'b1);
      end
    end
  end

  // Enable exclusivity and read-enable hold length.
  initial begin : mon
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (dif.drv_en_read || dif.drv_en_erase || dif.drv_en_write) begin
        vectors++;
        if ($countones({dif.drv_en_read, dif.drv_en_erase, dif.drv_en_write}) > 1) begin
          miscompares++;
          $display("FAIL enable_exclusive got r/e/w=%b%b%b, required at most one",
                   dif.drv_en_read, dif.drv_en_erase, dif.drv_en_write);
        end
      end
      if (dif.drv_en_read) run++;
      else if (run != 0) begin
        vectors++;
        if (run != READ_HOLD) begin
          miscompares++;
          $display("FAIL read_hold got %0d cycles, required %0d", run, READ_HOLD);
        end
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic fill_bytes(input int n_words);
    byte_q.delete();
    for (int i = 0; i < 2 * n_words; i++) byte_q.push_back(8'($urandom));
  endtask

  task automatic wait_drv_idle(input string tag);
    int c;
    c = 0;
    while (!(dif.drv_read_finish && dif.drv_erase_finish && dif.drv_write_finish) && c < 200) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 200) begin
      vectors++; miscompares++;
      $display("FAIL %s drv_idle timeout, required all finish levels high", tag);
    end
    repeat (10) begin @(posedge clk); #1; end
  endtask

  // One complete run: reference expectations come from the byte list and address rules.
  task automatic run_job(input logic [21:0] base, input logic [21:0] cnt,
                         input bit ovr, input bit poke, input string tag);
    op_t         e;
    logic [21:0] a, exp_ea, exp_wd;
    logic [15:0] w;
    bit          exp_err, injected;
    int          idx, cyc;
    exp_q.delete();
    exp_err = 1'b0; exp_ea = '0; exp_wd = cnt;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 22'(i);
      w = {byte_q[2*i+1], byte_q[2*i]};
      if ((int'(a) % 65536) == 0) begin e.kind = 0; e.addr = a; e.data = '0; exp_q.push_back(e); end
      e.kind = 1; e.addr = a; e.data = w; exp_q.push_back(e);
      if (ovr && i == 0) begin exp_err = 1'b1; exp_ea = a; exp_wd = '0; break; end
      e.kind = 2; e.addr = a; e.data = '0; exp_q.push_back(e);
      if (corrupt_en && a == corrupt_a) begin exp_err = 1'b1; exp_ea = a; exp_wd = 22'(i); break; end
    end

    op_log.delete();
    @(posedge clk); #1;
    base_addr = base; word_count = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; injected = 1'b0;
    while (busy && cyc < 5000) begin
      rx_valid = 1'b0; start = 1'b0;
      if (rx_ready && idx < byte_q.size() && $urandom_range(0, 2) != 0) begin
        rx_data = byte_q[idx]; rx_valid = 1'b1; idx++;
      end else if (ovr && !injected && !rx_ready && !dif.drv_en_write && !dif.drv_write_finish) begin
        rx_data = 8'hEE; rx_valid = 1'b1; injected = 1'b1;
      end else if (poke && cyc == 5) begin
        base_addr = 22'h000123; word_count = 22'd7; start = 1'b1;
      end
      @(posedge clk); #1; cyc++;
    end
    rx_valid = 1'b0; start = 1'b0;
    if (cyc >= 5000) begin
      vectors++; miscompares++;
      $display("FAIL %s busy_timeout busy=%b, required 0", tag, busy);
    end
    wait_drv_idle(tag);

    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy got %b required 0", tag, busy); end
    vectors++;
    if (done !== !exp_err) begin miscompares++; $display("FAIL %s done got %b required %b", tag, done, !exp_err); end
    vectors++;
    if (error !== exp_err) begin miscompares++; $display("FAIL %s error got %b required %b", tag, error, exp_err); end
    if (exp_err) begin
      vectors++;
      if (err_addr !== exp_ea) begin miscompares++; $display("FAIL %s err_addr got %h required %h", tag, err_addr, exp_ea); end
    end
    vectors++;
    if (words_done !== exp_wd) begin miscompares++; $display("FAIL %s words_done got %0d required %0d", tag, words_done, exp_wd); end
    vectors++;
    if (op_log.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s op_count got %0d required %0d", tag, op_log.size(), exp_q.size());
    end
    for (int i = 0; i < op_log.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (op_log[i].kind != exp_q[i].kind || op_log[i].addr !== exp_q[i].addr || op_log[i].data !== exp_q[i].data) begin
        miscompares++;
        $display("FAIL %s op[%0d] got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h", tag, i,
                 op_log[i].kind, op_log[i].addr, op_log[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, error, rx_ready} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags got busy/done/error/rx_ready=%b required 0000", {busy, done, error, rx_ready});
    end
    vectors++;
    if ({dif.drv_en_read, dif.drv_en_erase, dif.drv_en_write} !== 3'b0) begin
      miscompares++; $display("FAIL reset_enables got %b required 000", {dif.drv_en_read, dif.drv_en_erase, dif.drv_en_write});
    end
    vectors++;
    if (err_addr !== '0 || words_done !== '0 || dif.drv_addr !== '0 || dif.drv_wdata !== '0) begin
      miscompares++; $display("FAIL reset_values got err_addr=%h words_done=%h drv_addr=%h drv_wdata=%h required 0",
                              err_addr, words_done, dif.drv_addr, dif.drv_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned();
    byte_q = '{8'h34, 8'h12, 8'h78, 8'h56};
    run_job(22'h010000, 22'd2, 1'b0, 1'b0, "aligned");
    vectors++;
    if (!mem.exists(22'h010000) || mem[22'h010000] !== 16'h1234) begin
      miscompares++; $display("FAIL aligned mem0 got %h required 1234", mem.exists(22'h010000) ? mem[22'h010000] : 16'hxxxx);
    end
    vectors++;
    if (!mem.exists(22'h010001) || mem[22'h010001] !== 16'h5678) begin
      miscompares++; $display("FAIL aligned mem1 got %h required 5678", mem.exists(22'h010001) ? mem[22'h010001] : 16'hxxxx);
    end
  endtask

  task automatic test_unaligned();
    fill_bytes(2);
    run_job(22'h01FFFF, 22'd2, 1'b0, 1'b0, "unaligned");
  endtask

  task automatic test_wrap();
    fill_bytes(2);
    run_job(22'h3FFFFF, 22'd2, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_verify_mismatch();
    fill_bytes(4);
    byte_q[4] = 8'h00;  // word at 0x000005 must differ from the corrupted 0xFFFF
    corrupt_en = 1'b1; corrupt_a = 22'h000005;
    run_job(22'h000003, 22'd4, 1'b0, 1'b0, "verify_mismatch");
    corrupt_en = 1'b0;
  endtask

  task automatic test_overrun();
    fill_bytes(2);
    run_job(22'h000100, 22'd2, 1'b1, 1'b0, "overrun");
  endtask

  task automatic test_zero_count();
    op_log.delete();
    @(posedge clk); #1;
    base_addr = 22'h000040; word_count = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL zero_count_fin got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1 || error !== 1'b0) begin
      miscompares++; $display("FAIL zero_count_done got busy=%b done=%b error=%b required 0 1 0", busy, done, error);
    end
    repeat (5) begin @(posedge clk); #1; end
    vectors++;
    if (op_log.size() != 0) begin
      miscompares++; $display("FAIL zero_count_ops got %0d required 0", op_log.size());
    end
  endtask

  task automatic test_idle_drop();
    @(posedge clk); #1;
    rx_data = 8'h5A; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    vectors++;
    if (error !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      miscompares++; $display("FAIL idle_drop got error=%b busy=%b rx_ready=%b required 0 0 0", error, busy, rx_ready);
    end
  endtask

  task automatic test_reset_mid();
    int  cyc, idx;
    bit  seen, hit;
    byte_q = '{8'hAA, 8'h55};
    @(posedge clk); #1;
    base_addr = 22'h020000; word_count = 22'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; idx = 0; seen = 1'b0; hit = 1'b0;
    while (cyc < 500) begin
      rx_valid = 1'b0;
      if (seen && !dif.drv_en_erase && !dif.drv_erase_finish) begin hit = 1'b1; break; end
      if (dif.drv_en_erase) seen = 1'b1;
      if (rx_ready && idx < 2) begin rx_data = byte_q[idx]; rx_valid = 1'b1; idx++; end
      @(posedge clk); #1; cyc++;
    end
    rx_valid = 1'b0;
    vectors++;
    if (!hit) begin
      miscompares++; $display("FAIL reset_mid erase_wait_reached got 0 required 1");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({dif.drv_en_read, dif.drv_en_erase, dif.drv_en_write} !== 3'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid got enables=%b busy=%b rx_ready=%b required 000 0 0",
                              {dif.drv_en_read, dif.drv_en_erase, dif.drv_en_write}, busy, rx_ready);
    end
    rst = 1'b0;
    wait_drv_idle("reset_mid");
  endtask

  task automatic test_random();
    logic [21:0] b;
    logic [21:0] n;
    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 2))
        0:       b = 22'($urandom);
        1:       b = {6'($urandom), 16'hFFFF - 16'($urandom_range(0, 2))};
        default: b = {6'($urandom), 16'h0000};
      endcase
      n = 22'($urandom_range(1, 4));
      fill_bytes(int'(n));
      run_job(b, n, 1'b0, 1'b0, $sformatf("random%0d", t));
    end
  endtask

  task automatic test_back_to_back();
    fill_bytes(3);
    run_job(22'h00FFFE, 22'd3, 1'b0, 1'b1, "b2b_first");
    fill_bytes(2);
    run_job(22'h2A0010, 22'd2, 1'b0, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_verify_mismatch();
    test_overrun();
    test_zero_count();
    test_idle_drop();
    test_wrap();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
